// File: rtl/scaler_cfg_ctrl_if.sv
// Configuration bus between a host and scaler_cfg_ctrl.
// Carries the pending window/resolution request and the active results.
interface scaler_cfg_ctrl_if #(
    parameter int INPUT_RES_WIDTH  = 11,
    parameter int OUTPUT_RES_WIDTH = 11,
    parameter int SCALE_INT_WIDTH  = 2,
    parameter int SCALE_FRAC_WIDTH = 6,
    parameter int SCALE_BITS       = SCALE_INT_WIDTH + SCALE_FRAC_WIDTH
);
    logic                        cfg_wr;
    logic [INPUT_RES_WIDTH-1:0]  cfg_xBgn;
    logic [INPUT_RES_WIDTH-1:0]  cfg_xEnd;
    logic [INPUT_RES_WIDTH-1:0]  cfg_yBgn;
    logic [INPUT_RES_WIDTH-1:0]  cfg_yEnd;
    logic [OUTPUT_RES_WIDTH-1:0] cfg_outXRes;
    logic [OUTPUT_RES_WIDTH-1:0] cfg_outYRes;
    logic                        err_clr;

    logic [INPUT_RES_WIDTH-1:0]  xBgn;
    logic [INPUT_RES_WIDTH-1:0]  xEnd;
    logic [INPUT_RES_WIDTH-1:0]  yBgn;
    logic [INPUT_RES_WIDTH-1:0]  yEnd;
    logic [OUTPUT_RES_WIDTH-1:0] outXRes;
    logic [OUTPUT_RES_WIDTH-1:0] outYRes;
    logic [SCALE_BITS-1:0]       xScale;
    logic [SCALE_BITS-1:0]       yScale;
    logic                        cfg_busy;
    logic                        cfg_vld;
    logic [3:0]                  cfg_err;

    modport master (
        output cfg_wr, cfg_xBgn, cfg_xEnd, cfg_yBgn, cfg_yEnd,
        output cfg_outXRes, cfg_outYRes, err_clr,
        input  xBgn, xEnd, yBgn, yEnd, outXRes, outYRes,
        input  xScale, yScale, cfg_busy, cfg_vld, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_xBgn, cfg_xEnd, cfg_yBgn, cfg_yEnd,
        input  cfg_outXRes, cfg_outYRes, err_clr,
        output xBgn, xEnd, yBgn, yEnd, outXRes, outYRes,
        output xScale, yScale, cfg_busy, cfg_vld, cfg_err
    );
endinterface

// File: rtl/scaler_cfg_ctrl.sv
// Scaler configuration controller: validates a crop/output request at a
// frame boundary and derives fixed-point scale factors by serial division.
module scaler_cfg_ctrl #(
    parameter int INPUT_RES_WIDTH  = 11,
    parameter int OUTPUT_RES_WIDTH = 11,
    parameter int SCALE_INT_WIDTH  = 2,
    parameter int SCALE_FRAC_WIDTH = 6,
    parameter int SCALE_BITS       = SCALE_INT_WIDTH + SCALE_FRAC_WIDTH
) (
    input  logic               clka,
    input  logic               rst,
    input  logic               iVsyn,
    scaler_cfg_ctrl_if.slave   bus
);
    localparam int IW = INPUT_RES_WIDTH;
    localparam int OW = OUTPUT_RES_WIDTH;
    localparam int FW = SCALE_FRAC_WIDTH;
    localparam int SB = SCALE_BITS;
    localparam int N  = IW + 1 + FW;
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV_X,
        S_DIV_Y,
        S_COMMIT
    } state_t;

    state_t        r_state;
    logic          r_vsyn_d;
    logic          r_pend;

    logic [IW-1:0] r_p_xb, r_p_xe, r_p_yb, r_p_ye;
    logic [OW-1:0] r_p_ox, r_p_oy;

    logic [IW-1:0] r_s_xb, r_s_xe, r_s_yb, r_s_ye;
    logic [OW-1:0] r_s_ox, r_s_oy;
    logic [IW:0]   r_wid_y;

    logic [N-1:0]  r_dvd;
    logic [OW-1:0] r_rem;
    logic [N-2:0]  r_quo;
    logic [CW-1:0] r_cnt;
    logic [SB-1:0] r_sc_x;
    logic [SB-1:0] r_sc_y;

    logic [IW-1:0] r_xb, r_xe, r_yb, r_ye;
    logic [OW-1:0] r_ox, r_oy;
    logic [SB-1:0] r_xs, r_ys;
    logic          r_busy;
    logic          r_vld;
    logic [3:0]    r_err;

    logic          w_frame;
    logic          w_rev;
    logic          w_zero;
    logic [IW:0]   w_wid_x;
    logic [IW:0]   w_wid_y;
    logic [OW-1:0] w_divisor;
    logic [OW:0]   w_rem_sh;
    logic          w_ge;
    logic [OW-1:0] w_rem_sub;
    logic [OW-1:0] w_rem_nxt;
    logic [N-1:0]  w_quo_nxt;
    logic          w_sat;
    logic [SB-1:0] w_scale;
    logic          w_last;
    logic          w_div;
    logic [3:0]    w_err_set;

    assign w_frame = iVsyn & ~r_vsyn_d;

    // Validity is judged on the pending copy, which CHECK snapshots.
    assign w_rev  = (r_p_xe < r_p_xb) | (r_p_ye < r_p_yb);
    assign w_zero = (r_p_ox == '0) | (r_p_oy == '0);

    assign w_wid_x = {1'b0, r_p_xe} - {1'b0, r_p_xb} + (IW+1)'(1);
    assign w_wid_y = {1'b0, r_p_ye} - {1'b0, r_p_yb} + (IW+1)'(1);

    // Restoring division step; remainder stays below the divisor.
    assign w_divisor = (r_state == S_DIV_Y) ? r_s_oy : r_s_ox;
    assign w_rem_sh  = {r_rem, r_dvd[N-1]};
    assign w_ge      = w_rem_sh >= {1'b0, w_divisor};
    assign w_rem_sub = w_rem_sh[OW-1:0] - w_divisor;
    assign w_rem_nxt = w_ge ? w_rem_sub : w_rem_sh[OW-1:0];
    assign w_quo_nxt = {r_quo, w_ge};

    assign w_sat   = |w_quo_nxt[N-1:SB];
    assign w_scale = w_sat ? {SB{1'b1}} : w_quo_nxt[SB-1:0];
    assign w_last  = r_cnt == CW'(N - 1);
    assign w_div   = (r_state == S_DIV_X) | (r_state == S_DIV_Y);

    assign w_err_set[0] = (r_state == S_CHECK) & w_rev;
    assign w_err_set[1] = (r_state == S_CHECK) & w_zero;
    assign w_err_set[2] = (r_state != S_IDLE) & w_frame;
    assign w_err_set[3] = w_div & w_last & w_sat;

    // Pending request: latest write wins, CHECK consumes it.
    always_ff @(posedge clka) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_p_xb <= '0;
            r_p_xe <= '0;
            r_p_yb <= '0;
            r_p_ye <= '0;
            r_p_ox <= '0;
            r_p_oy <= '0;
        end else if (bus.cfg_wr) begin
            r_pend <= 1'b1;
            r_p_xb <= bus.cfg_xBgn;
            r_p_xe <= bus.cfg_xEnd;
            r_p_yb <= bus.cfg_yBgn;
            r_p_ye <= bus.cfg_yEnd;
            r_p_ox <= bus.cfg_outXRes;
            r_p_oy <= bus.cfg_outYRes;
        end else if (r_state == S_CHECK) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_vsyn_d <= 1'b0;
            r_busy   <= 1'b0;
            r_vld    <= 1'b0;
            r_err    <= '0;
            r_s_xb   <= '0;
            r_s_xe   <= '0;
            r_s_yb   <= '0;
            r_s_ye   <= '0;
            r_s_ox   <= '0;
            r_s_oy   <= '0;
            r_wid_y  <= '0;
            r_dvd    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_sc_x   <= '0;
            r_sc_y   <= '0;
            r_xb     <= '0;
            r_xe     <= '0;
            r_yb     <= '0;
            r_ye     <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_xs     <= '0;
            r_ys     <= '0;
        end else begin
            r_vsyn_d <= iVsyn;
            r_vld    <= 1'b0;
            r_err    <= (bus.err_clr ? 4'b0 : r_err) | w_err_set;
            unique case (r_state)
                S_IDLE: begin
                    if (w_frame && (r_pend || bus.cfg_wr)) begin
                        r_state <= S_CHECK;
                        r_busy  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    r_s_xb  <= r_p_xb;
                    r_s_xe  <= r_p_xe;
                    r_s_yb  <= r_p_yb;
                    r_s_ye  <= r_p_ye;
                    r_s_ox  <= r_p_ox;
                    r_s_oy  <= r_p_oy;
                    r_wid_y <= w_wid_y;
                    r_dvd   <= {w_wid_x, {FW{1'b0}}};
                    r_rem   <= '0;
                    r_quo   <= '0;
                    r_cnt   <= '0;
                    if (w_rev || w_zero) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_DIV_X;
                    end
                end
                S_DIV_X: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt[N-2:0];
                    r_dvd <= {r_dvd[N-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sc_x  <= w_scale;
                        r_dvd   <= {r_wid_y, {FW{1'b0}}};
                        r_rem   <= '0;
                        r_quo   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_DIV_Y;
                    end
                end
                S_DIV_Y: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt[N-2:0];
                    r_dvd <= {r_dvd[N-2:0], 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sc_y  <= w_scale;
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_xb    <= r_s_xb;
                    r_xe    <= r_s_xe;
                    r_yb    <= r_s_yb;
                    r_ye    <= r_s_ye;
                    r_ox    <= r_s_ox;
                    r_oy    <= r_s_oy;
                    r_xs    <= r_sc_x;
                    r_ys    <= r_sc_y;
                    r_vld   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.xBgn     = r_xb;
    assign bus.xEnd     = r_xe;
    assign bus.yBgn     = r_yb;
    assign bus.yEnd     = r_ye;
    assign bus.outXRes  = r_ox;
    assign bus.outYRes  = r_oy;
    assign bus.xScale   = r_xs;
    assign bus.yScale   = r_ys;
    assign bus.cfg_busy = r_busy;
    assign bus.cfg_vld  = r_vld;
    assign bus.cfg_err  = r_err;

endmodule

// File: doc/scaler_cfg_ctrl.md
SCALER_CFG_CTRL -- requirements
Module: scaler_cfg_ctrl

Interface
REQ-001 Parameter INPUT_RES_WIDTH, default 11: width of input crop coordinates.
REQ-002 Parameter OUTPUT_RES_WIDTH, default 11: width of output resolution fields.
REQ-003 Parameter SCALE_INT_WIDTH, default 2: integer bits of scale factor.
REQ-004 Parameter SCALE_FRAC_WIDTH, default 6: fraction bits of scale factor.
REQ-005 Parameter SCALE_BITS, default SCALE_INT_WIDTH+SCALE_FRAC_WIDTH: scale factor width.
REQ-006 Derived constant N = INPUT_RES_WIDTH+1+SCALE_FRAC_WIDTH, the divider iteration count (18 at defaults).
REQ-007 clka  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 iVsyn  in  1  frame sync level; a rising edge marks a frame boundary.
REQ-010 cfg_wr  in  1  one-cycle strobe capturing all cfg_* inputs into pending registers.
REQ-011 cfg_xBgn, cfg_xEnd, cfg_yBgn, cfg_yEnd  in  INPUT_RES_WIDTH each  requested crop window, inclusive.
REQ-012 cfg_outXRes, cfg_outYRes  in  OUTPUT_RES_WIDTH each  requested output resolution.
REQ-013 err_clr  in  1  clears cfg_err.
REQ-014 xBgn, xEnd, yBgn, yEnd  out  INPUT_RES_WIDTH each  active crop window.
REQ-015 outXRes, outYRes  out  OUTPUT_RES_WIDTH each  active output resolution.
REQ-016 xScale, yScale  out  SCALE_BITS each  active scale factor, unsigned fixed-point INT.FRAC.
REQ-017 cfg_busy  out  1  high while a configuration is being validated or computed.
REQ-018 cfg_vld  out  1  one-cycle pulse when the active outputs update.
REQ-019 cfg_err  out  4  sticky error flags: [0] window reversed, [1] zero output resolution, [2] vsync while busy, [3] scale saturated.

Function
REQ-020 Registered copy iVsyn_d; a frame edge is the cycle with iVsyn=1 and iVsyn_d=0.
REQ-021 cfg_wr loads the pending registers and sets flag pend, in any state; latest write wins.
REQ-022 FSM states: IDLE, CHECK, DIV_X, DIV_Y, COMMIT.
REQ-023 IDLE -> CHECK on a frame edge with pend=1 or cfg_wr=1; a frame edge with neither pending nor writing keeps IDLE.
REQ-024 In CHECK, snapshot the pending registers and clear pend; a cfg_wr in the same CHECK cycle re-sets pend for the next frame.
REQ-025 In CHECK, xEnd<xBgn or yEnd<yBgn sets cfg_err[0]; outXRes=0 or outYRes=0 sets cfg_err[1]; on any of these, go to IDLE with active outputs unchanged and no cfg_vld.
REQ-026 In CHECK with a valid snapshot, compute widthX = xEnd-xBgn+1 and widthY = yEnd-yBgn+1 in INPUT_RES_WIDTH+1 bits, then go to DIV_X.
REQ-027 DIV_X runs N cycles of restoring division, one quotient bit per cycle, MSB first: qX = floor(widthX*2^SCALE_FRAC_WIDTH / outXRes). DIV_Y does the same for qY, then goes to COMMIT.
REQ-028 If a quotient is >= 2^SCALE_BITS, that scale becomes all-ones and cfg_err[3] is set; otherwise scale = quotient[SCALE_BITS-1:0].
REQ-029 COMMIT loads all active outputs from the snapshot and the computed scales, pulses cfg_vld for exactly one cycle, and returns to IDLE.
REQ-030 Latency: cfg_vld is high in the cycle 2N+3 clocks after the frame-edge cycle (39 at defaults); active outputs change on that same edge.
REQ-031 cfg_busy is high in CHECK, DIV_X, DIV_Y and COMMIT, and low in IDLE.
REQ-032 A frame edge while cfg_busy=1 sets cfg_err[2], does not restart the computation, and does not consume pend.
REQ-033 cfg_err bits stay set until err_clr or rst; when err_clr and a new error occur in the same cycle, the new error bit stays set.
REQ-034 Active outputs change only in COMMIT.

Reset
REQ-035 When rst=1 at a clock edge, the FSM goes to IDLE and pend, iVsyn_d, cfg_busy, cfg_vld, cfg_err and all active outputs become 0; this applies in any state, including mid-division.
REQ-036 After rst is released, a frame edge without a new cfg_wr does not start a computation.

Verification
REQ-037 Scenario: write window 0..719 x 0..1279, out 360x640, then raise iVsyn -> cfg_vld 39 cycles later, xScale=128, yScale=128, cfg_err=0.
REQ-038 Scenario: window 0..719, outXRes=1080 -> xScale=42 (0.65625), no saturation.
REQ-039 Scenario: window 0..2047, outXRes=100 -> xScale=255, cfg_err[3]=1.
REQ-040 Scenario: xBgn=100, xEnd=50, then frame edge -> cfg_err[0]=1, cfg_vld never asserts, active outputs hold their previous values.
REQ-041 Scenario: second frame edge 10 cycles after the first -> cfg_err[2]=1, the first result still commits at cycle 39; a cfg_wr during busy commits on the following frame.
REQ-042 Scenario: rst asserted during DIV_Y -> next cycle all outputs are 0 and cfg_busy=0; a later frame edge with no cfg_wr produces no cfg_vld.
